// File: rtl/zap_branch_resolver.sv
// zap_branch_resolver: in-order tracker of predicted branches that
// resolves the oldest entry and produces BTB feedback and resync PC.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_clear                 pipeline flush, empties the tracker
//   i_push, i_push_*        fetch-side predicted branch entry
//   o_full, o_empty         tracker occupancy flags
//   i_resolve, i_res_*      execute-side actual outcome of oldest entry
//   o_fb_*                  registered BTB feedback (pulses + data)
//   o_clear_from_resolver   resync pulse on misprediction
//   o_pc_from_resolver      corrected fetch PC
//   o_err                   sticky overflow/underflow flag
module zap_branch_resolver #(
  parameter int DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [31:0] i_push_pc,
  input  logic [1:0]  i_push_state,
  input  logic [31:0] i_push_target,
  output logic        o_full,
  output logic        o_empty,
  input  logic        i_resolve,
  input  logic        i_res_taken,
  input  logic [31:0] i_res_target,
  input  logic [31:0] i_res_fallthrough,
  output logic        o_fb_ok,
  output logic        o_fb_nok,
  output logic [31:0] o_fb_branch_src_address,
  output logic [1:0]  o_fb_current_branch_state,
  output logic [31:0] o_fb_branch_dest_address,
  output logic        o_clear_from_resolver,
  output logic [31:0] o_pc_from_resolver,
  output logic        o_err
);

  localparam int AW = $clog2(DEPTH);

  logic [65:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [31:0] e_pc;
  logic [1:0]  e_state;
  logic [31:0] e_tgt;
  logic        do_push;
  logic        do_res;
  logic        res_ok;
  logic        mispredict;
  logic        flush;
  logic        push_ok;
  logic        push_err;
  logic        res_err;

  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);

  assign {e_pc, e_state, e_tgt} = mem[rd_ptr];

  // i_clear masks both request sides so nothing it cancels can flag
  // an error.
  assign do_push = i_push & ~i_clear;
  assign do_res  = i_resolve & ~i_clear;
  assign res_ok  = do_res & ~o_empty;

  assign mispredict =
    (e_state[1] != i_res_taken) |
    (e_state[1] & i_res_taken & (e_tgt != i_res_target));

  assign flush = res_ok & mispredict;

  // A pop in the same cycle frees the slot a full push needs; a push
  // alongside a mispredict is wrong-path and silently dropped.
  assign push_ok  = do_push & (~o_full | res_ok) & ~flush;
  assign push_err = do_push & o_full & ~res_ok;
  assign res_err  = do_res & o_empty;

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {i_push_pc, i_push_state, i_push_target};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_clear | flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (res_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, res_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fb_ok                   <= 1'b0;
      o_fb_nok                  <= 1'b0;
      o_clear_from_resolver     <= 1'b0;
      o_fb_branch_src_address   <= '0;
      o_fb_current_branch_state <= '0;
      o_fb_branch_dest_address  <= '0;
      o_pc_from_resolver        <= '0;
      o_err                     <= 1'b0;
    end else begin
      o_fb_ok               <= res_ok & ~mispredict;
      o_fb_nok              <= flush;
      o_clear_from_resolver <= flush;
      o_err                 <= o_err | push_err | res_err;
      if (res_ok) begin
        o_fb_branch_src_address   <= e_pc;
        o_fb_current_branch_state <= e_state;
        o_fb_branch_dest_address  <=
          i_res_taken ? i_res_target : e_tgt;
      end
      if (flush) begin
        o_pc_from_resolver <=
          i_res_taken ? i_res_target : i_res_fallthrough;
      end
    end
  end

endmodule

// File: tb/tb_zap_branch_resolver.sv
// Directed bench for zap_branch_resolver.
// Drives after each rising edge, checks #1 after the next one.
module tb_zap_branch_resolver;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_clear;
  logic        i_push;
  logic [31:0] i_push_pc;
  logic [1:0]  i_push_state;
  logic [31:0] i_push_target;
  logic        o_full;
  logic        o_empty;
  logic        i_resolve;
  logic        i_res_taken;
  logic [31:0] i_res_target;
  logic [31:0] i_res_fallthrough;
  logic        o_fb_ok;
  logic        o_fb_nok;
  logic [31:0] o_fb_branch_src_address;
  logic [1:0]  o_fb_current_branch_state;
  logic [31:0] o_fb_branch_dest_address;
  logic        o_clear_from_resolver;
  logic [31:0] o_pc_from_resolver;
  logic        o_err;

  int total = 0;
  int bad   = 0;

  zap_branch_resolver #(.DEPTH(8)) dut (
    .i_clk                     (i_clk),
    .i_reset                   (i_reset),
    .i_clear                   (i_clear),
    .i_push                    (i_push),
    .i_push_pc                 (i_push_pc),
    .i_push_state              (i_push_state),
    .i_push_target             (i_push_target),
    .o_full                    (o_full),
    .o_empty                   (o_empty),
    .i_resolve                 (i_resolve),
    .i_res_taken               (i_res_taken),
    .i_res_target              (i_res_target),
    .i_res_fallthrough         (i_res_fallthrough),
    .o_fb_ok                   (o_fb_ok),
    .o_fb_nok                  (o_fb_nok),
    .o_fb_branch_src_address   (o_fb_branch_src_address),
    .o_fb_current_branch_state (o_fb_current_branch_state),
    .o_fb_branch_dest_address  (o_fb_branch_dest_address),
    .o_clear_from_resolver     (o_clear_from_resolver),
    .o_pc_from_resolver        (o_pc_from_resolver),
    .o_err                     (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_clear           = 1'b0;
    i_push            = 1'b0;
    i_push_pc         = '0;
    i_push_state      = '0;
    i_push_target     = '0;
    i_resolve         = 1'b0;
    i_res_taken       = 1'b0;
    i_res_target      = '0;
    i_res_fallthrough = '0;
  endtask

  task automatic set_push(input logic [31:0] pc,
                          input logic [1:0] st,
                          input logic [31:0] tgt);
    i_push        = 1'b1;
    i_push_pc     = pc;
    i_push_state  = st;
    i_push_target = tgt;
  endtask

  task automatic set_res(input logic taken,
                         input logic [31:0] tgt,
                         input logic [31:0] fall);
    i_resolve         = 1'b1;
    i_res_taken       = taken;
    i_res_target      = tgt;
    i_res_fallthrough = fall;
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_ok", 32'(o_fb_ok), 32'd0);
    chk("rst_nok", 32'(o_fb_nok), 32'd0);
    chk("rst_clr", 32'(o_clear_from_resolver), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_src", o_fb_branch_src_address, 32'h0);
    chk("rst_pc", o_pc_from_resolver, 32'h0);

    // correct taken prediction
    idle(); set_push(32'h100, 2'd3, 32'h200); tick();
    chk("t1_notempty", 32'(o_empty), 32'd0);
    idle(); set_res(1'b1, 32'h200, 32'h104); tick();
    chk("t1_ok", 32'(o_fb_ok), 32'd1);
    chk("t1_nok", 32'(o_fb_nok), 32'd0);
    chk("t1_src", o_fb_branch_src_address, 32'h100);
    chk("t1_state", 32'(o_fb_current_branch_state), 32'd3);
    chk("t1_dest", o_fb_branch_dest_address, 32'h200);
    chk("t1_clr", 32'(o_clear_from_resolver), 32'd0);
    chk("t1_empty", 32'(o_empty), 32'd1);
    idle(); tick();
    chk("t1_pulse", 32'(o_fb_ok), 32'd0);
    chk("t1_hold", o_fb_branch_src_address, 32'h100);

    // predicted taken, actually not taken
    idle(); set_push(32'h104, 2'd2, 32'h300); tick();
    idle(); set_res(1'b0, 32'h0, 32'h108); tick();
    chk("t2_nok", 32'(o_fb_nok), 32'd1);
    chk("t2_ok", 32'(o_fb_ok), 32'd0);
    chk("t2_dest", o_fb_branch_dest_address, 32'h300);
    chk("t2_clr", 32'(o_clear_from_resolver), 32'd1);
    chk("t2_pc", o_pc_from_resolver, 32'h108);
    idle(); tick();
    chk("t2_clr_pulse", 32'(o_clear_from_resolver), 32'd0);
    chk("t2_pc_hold", o_pc_from_resolver, 32'h108);

    // taken both ways but wrong target
    idle(); set_push(32'h500, 2'd3, 32'h600); tick();
    idle(); set_res(1'b1, 32'h700, 32'h504); tick();
    chk("tt_nok", 32'(o_fb_nok), 32'd1);
    chk("tt_dest", o_fb_branch_dest_address, 32'h700);
    chk("tt_pc", o_pc_from_resolver, 32'h700);

    // mispredict discards younger entries
    idle(); set_push(32'h10, 2'd0, 32'h14); tick();
    idle(); set_push(32'h20, 2'd0, 32'h24); tick();
    idle(); set_push(32'h30, 2'd0, 32'h34); tick();
    idle(); set_res(1'b1, 32'h80, 32'h14); tick();
    chk("t3_nok", 32'(o_fb_nok), 32'd1);
    chk("t3_src", o_fb_branch_src_address, 32'h10);
    chk("t3_pc", o_pc_from_resolver, 32'h80);
    chk("t3_empty", 32'(o_empty), 32'd1);
    chk("t3_err", 32'(o_err), 32'd0);

    // resolve while empty
    idle(); set_res(1'b0, 32'h0, 32'h0); tick();
    chk("t5_ok", 32'(o_fb_ok), 32'd0);
    chk("t5_nok", 32'(o_fb_nok), 32'd0);
    chk("t5_err", 32'(o_err), 32'd1);
    chk("t5_src_hold", o_fb_branch_src_address, 32'h10);

    // overflow
    do_reset();
    chk("t4_err_rst", 32'(o_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      idle(); set_push(32'h1000 + 32'(i * 4), 2'd0, 32'h0); tick();
    end
    chk("t4_full", 32'(o_full), 32'd1);
    idle(); set_push(32'hDEAD, 2'd0, 32'h0); tick();
    chk("t4_full9", 32'(o_full), 32'd1);
    chk("t4_err9", 32'(o_err), 32'd1);
    idle(); set_res(1'b0, 32'h0, 32'h0); tick();
    chk("t4_first", o_fb_branch_src_address, 32'h1000);
    chk("t4_after_pop", 32'(o_full), 32'd0);

    // full push+resolve together
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); set_push(32'h2000 + 32'(i * 4), 2'd0, 32'h0); tick();
    end
    idle();
    set_push(32'h2020, 2'd1, 32'h0);
    set_res(1'b0, 32'h0, 32'h0);
    tick();
    chk("t4b_ok", 32'(o_fb_ok), 32'd1);
    chk("t4b_src", o_fb_branch_src_address, 32'h2000);
    chk("t4b_full", 32'(o_full), 32'd1);
    chk("t4b_err", 32'(o_err), 32'd0);
    for (int i = 1; i < 9; i++) begin
      idle(); set_res(1'b0, 32'h0, 32'h0); tick();
      chk("t4b_drain", o_fb_branch_src_address,
          32'h2000 + 32'(i * 4));
      chk("t4b_drain_ok", 32'(o_fb_ok), 32'd1);
    end
    chk("t4b_state", 32'(o_fb_current_branch_state), 32'd1);
    chk("t4b_empty", 32'(o_empty), 32'd1);

    // clear beats push and resolve
    for (int i = 0; i < 3; i++) begin
      idle(); set_push(32'h3000 + 32'(i * 4), 2'd2, 32'h3100); tick();
    end
    idle();
    i_clear = 1'b1;
    set_push(32'h3100, 2'd0, 32'h0);
    set_res(1'b0, 32'h0, 32'h3004);
    tick();
    chk("t6_empty", 32'(o_empty), 32'd1);
    chk("t6_ok", 32'(o_fb_ok), 32'd0);
    chk("t6_nok", 32'(o_fb_nok), 32'd0);
    chk("t6_clr", 32'(o_clear_from_resolver), 32'd0);
    chk("t6_err", 32'(o_err), 32'd0);
    chk("t6_src_hold", o_fb_branch_src_address, 32'h2020);

    // wrap-around, pipelined push/resolve
    idle(); set_push(32'h4000, 2'd1, 32'h0); tick();
    for (int i = 1; i < 20; i++) begin
      idle();
      set_push(32'h4000 + 32'(i * 4), 2'd1, 32'h0);
      set_res(1'b0, 32'h0, 32'h0);
      tick();
      chk("t7_src", o_fb_branch_src_address,
          32'h4000 + 32'((i - 1) * 4));
      chk("t7_ok", 32'(o_fb_ok), 32'd1);
    end
    idle(); set_res(1'b0, 32'h0, 32'h0); tick();
    chk("t7_last", o_fb_branch_src_address, 32'h404C);
    chk("t7_empty", 32'(o_empty), 32'd1);
    chk("t7_err", 32'(o_err), 32'd0);

    idle(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
